// File: rtl/core_guard_pkg.sv
// core_guard_pkg
// Shared definitions for the auto-guard controller.
//   guard_state_e   : controller states (READY, GUARDING, BLOCKSTUN, INHIBIT, BROKEN)
//   frame_cnt_width : bits needed to hold a frame count from 0 up to max_count
//   max3            : largest of three integers, used to size a shared counter
package core_guard_pkg;

    typedef enum logic [2:0] {
        READY     = 3'd0,
        GUARDING  = 3'd1,
        BLOCKSTUN = 3'd2,
        INHIBIT   = 3'd3,
        BROKEN    = 3'd4
    } guard_state_e;

    function automatic int frame_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/core_player_guard_if.sv
// core_player_guard_if
// Bundles the hit/collision-side inputs and the guard outputs of one fighter.
//   master : drives opponent hitbox info, player status and block hits; reads guard state
//   slave  : the guard controller, consuming the inputs and driving the guard outputs
// Inputs (master -> slave): frame_tick, op_hitbox_active, op_is_grab, op_is_low, op_is_overhead,
//   within_guard_range, in_front, crouch_held, action_active, action_start, neutral, hitstun,
//   blockhit_pulse, blockhit_cost
// Outputs (slave -> master): is_blocking, block_low, blockstun, guard_broken, guard_break_pulse,
//   guard_meter
interface core_player_guard_if #(
    parameter int NUM_HB  = 4,
    parameter int METER_W = 8
);
    logic                frame_tick;
    logic [NUM_HB-1:0]   op_hitbox_active;
    logic [NUM_HB-1:0]   op_is_grab;
    logic [NUM_HB-1:0]   op_is_low;
    logic [NUM_HB-1:0]   op_is_overhead;
    logic [NUM_HB-1:0]   within_guard_range;
    logic                in_front;
    logic                crouch_held;
    logic                action_active;
    logic                action_start;
    logic                neutral;
    logic                hitstun;
    logic                blockhit_pulse;
    logic [METER_W-1:0]  blockhit_cost;

    logic                is_blocking;
    logic                block_low;
    logic                blockstun;
    logic                guard_broken;
    logic                guard_break_pulse;
    logic [METER_W-1:0]  guard_meter;

    modport master (
        output frame_tick, op_hitbox_active, op_is_grab, op_is_low, op_is_overhead,
               within_guard_range, in_front, crouch_held, action_active, action_start,
               neutral, hitstun, blockhit_pulse, blockhit_cost,
        input  is_blocking, block_low, blockstun, guard_broken, guard_break_pulse, guard_meter
    );

    modport slave (
        input  frame_tick, op_hitbox_active, op_is_grab, op_is_low, op_is_overhead,
               within_guard_range, in_front, crouch_held, action_active, action_start,
               neutral, hitstun, blockhit_pulse, blockhit_cost,
        output is_blocking, block_low, blockstun, guard_broken, guard_break_pulse, guard_meter
    );

endinterface

// File: rtl/core_threat_window.sv
// core_threat_window
// Remembers per-channel threats for GUARD_WINDOW frames so a short-lived hitbox keeps the
// guard up for a few frames after it disappears.
//   clk, rst_n           : clock, async active-low reset
//   frame_tick           : history shifts only on this strobe
//   thr/thr_low/thr_ovh  : current threat, low-threat and overhead-threat bits per channel
//   window_any/low/ovh   : OR of the current bits and every remembered bit of that kind
module core_threat_window #(
    parameter int NUM_HB       = 4,
    parameter int GUARD_WINDOW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic [NUM_HB-1:0] thr,
    input  logic [NUM_HB-1:0] thr_low,
    input  logic [NUM_HB-1:0] thr_ovh,
    output logic              window_any,
    output logic              window_low,
    output logic              window_ovh
);

    // Stage 0 is the most recent frame; the oldest stage falls off the end.
    logic [GUARD_WINDOW-1:0][NUM_HB-1:0] any_sr_q, any_sr_d;
    logic [GUARD_WINDOW-1:0][NUM_HB-1:0] low_sr_q, low_sr_d;
    logic [GUARD_WINDOW-1:0][NUM_HB-1:0] ovh_sr_q, ovh_sr_d;

    always_comb begin
        any_sr_d = any_sr_q;
        low_sr_d = low_sr_q;
        ovh_sr_d = ovh_sr_q;
        if (frame_tick) begin
            any_sr_d = {any_sr_q[GUARD_WINDOW-2:0], thr};
            low_sr_d = {low_sr_q[GUARD_WINDOW-2:0], thr_low};
            ovh_sr_d = {ovh_sr_q[GUARD_WINDOW-2:0], thr_ovh};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_sr_q <= '0;
            low_sr_q <= '0;
            ovh_sr_q <= '0;
        end else begin
            any_sr_q <= any_sr_d;
            low_sr_q <= low_sr_d;
            ovh_sr_q <= ovh_sr_d;
        end
    end

    assign window_any = (|thr)     | (|any_sr_q);
    assign window_low = (|thr_low) | (|low_sr_q);
    assign window_ovh = (|thr_ovh) | (|ovh_sr_q);

endmodule

// File: rtl/core_player_guard.sv
// core_player_guard
// Auto-guard controller for one fighter: picks high/low guard from the opponent's hitbox
// channels, times blockstun, and runs a guard meter that drains on block hits, regenerates
// when left alone, and breaks the guard when it empties.
//   clk, rst_n : clock, async active-low reset
//   bus        : core_player_guard_if.slave carrying all hitbox/player inputs and guard outputs
module core_player_guard
    import core_guard_pkg::*;
#(
    parameter int NUM_HB        = 4,
    parameter int GUARD_WINDOW  = 3,
    parameter int INHIBIT_CLEAR = 2,
    parameter int BLOCKSTUN_FR  = 8,
    parameter int METER_W       = 8,
    parameter int GUARD_MAX     = 100,
    parameter int REGEN_DELAY   = 30,
    parameter int REGEN_PERIOD  = 4,
    parameter int BREAK_FR      = 40,
    parameter int BREAK_REFILL  = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    core_player_guard_if.slave bus
);

    // One frame counter serves BLOCKSTUN, INHIBIT and BROKEN since they never overlap.
    localparam int FCNT_W = frame_cnt_width(max3(BLOCKSTUN_FR, BREAK_FR, INHIBIT_CLEAR));
    localparam logic [FCNT_W-1:0] STUN_LOAD  = FCNT_W'(BLOCKSTUN_FR);
    localparam logic [FCNT_W-1:0] BREAK_LOAD = FCNT_W'(BREAK_FR);
    localparam logic [FCNT_W-1:0] INH_DONE   = FCNT_W'(INHIBIT_CLEAR);
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);

    localparam int DLY_W = frame_cnt_width(REGEN_DELAY);
    localparam int PER_W = frame_cnt_width(REGEN_PERIOD);
    localparam logic [DLY_W-1:0] DLY_MAX  = DLY_W'(REGEN_DELAY);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(REGEN_PERIOD - 1);

    localparam logic [METER_W-1:0] METER_FULL   = METER_W'(GUARD_MAX);
    localparam logic [METER_W-1:0] METER_REFILL = METER_W'(BREAK_REFILL);

    guard_state_e       state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [METER_W-1:0] meter_q, meter_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [PER_W-1:0]   per_q, per_d;

    logic is_blocking_q, is_blocking_d;
    logic block_low_q, block_low_d;
    logic blockstun_q, blockstun_d;
    logic guard_broken_q, guard_broken_d;
    logic break_pulse_q, break_pulse_d;

    logic [NUM_HB-1:0]  thr, thr_low, thr_ovh;
    logic               window_any, window_low, window_ovh;
    logic               stance_low;
    logic               blockhit_ok;
    logic               break_now;
    logic [METER_W-1:0] meter_sub;

    // A channel only threatens us if it is live, blockable, in range and coming from the front.
    assign thr     = bus.op_hitbox_active & ~bus.op_is_grab & bus.within_guard_range
                   & {NUM_HB{bus.in_front}};
    assign thr_low = thr & bus.op_is_low;
    assign thr_ovh = thr & bus.op_is_overhead;

    core_threat_window #(
        .NUM_HB       (NUM_HB),
        .GUARD_WINDOW (GUARD_WINDOW)
    ) u_window (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (bus.frame_tick),
        .thr        (thr),
        .thr_low    (thr_low),
        .thr_ovh    (thr_ovh),
        .window_any (window_any),
        .window_low (window_low),
        .window_ovh (window_ovh)
    );

    // Conflicting or absent height requirements fall back to what the player is holding.
    always_comb begin
        stance_low = bus.crouch_held;
        if (window_low && !window_ovh) begin
            stance_low = 1'b1;
        end else if (window_ovh && !window_low) begin
            stance_low = 1'b0;
        end
    end

    // Only hits that land on a raised guard cost meter; an empty meter breaks the guard.
    always_comb begin
        blockhit_ok = bus.blockhit_pulse && (state_q == GUARDING || state_q == BLOCKSTUN);
        meter_sub   = (bus.blockhit_cost >= meter_q) ? '0 : (meter_q - bus.blockhit_cost);
        break_now   = blockhit_ok && (meter_sub == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; within a state a block hit outranks hitstun, which outranks action_start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            READY: begin
                if (bus.action_start) begin
                    state_d = INHIBIT;
                end else if (window_any && !bus.action_active && !bus.hitstun) begin
                    state_d = GUARDING;
                end
            end
            GUARDING: begin
                if (bus.blockhit_pulse) begin
                    state_d = break_now ? BROKEN : BLOCKSTUN;
                end else if (bus.hitstun) begin
                    state_d = READY;
                end else if (bus.action_start) begin
                    state_d = INHIBIT;
                end else if (!window_any) begin
                    state_d = READY;
                end
            end
            BLOCKSTUN: begin
                if (bus.blockhit_pulse) begin
                    state_d = break_now ? BROKEN : BLOCKSTUN;
                end else if (bus.hitstun) begin
                    state_d = READY;
                end else if (bus.frame_tick && fcnt_q <= FCNT_ONE) begin
                    state_d = window_any ? GUARDING : READY;
                end
            end
            INHIBIT: begin
                if (!bus.action_start && bus.neutral && fcnt_q == INH_DONE) begin
                    state_d = READY;
                end
            end
            BROKEN: begin
                if (bus.frame_tick && fcnt_q <= FCNT_ONE) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    // Shared frame counter: counts down stun/break time, counts up neutral frames in INHIBIT.
    always_comb begin
        fcnt_d = '0;
        if (state_d == BLOCKSTUN && (state_q != BLOCKSTUN || bus.blockhit_pulse)) begin
            fcnt_d = STUN_LOAD;
        end else if (state_d == BROKEN && state_q != BROKEN) begin
            fcnt_d = BREAK_LOAD;
        end else if (state_d == BLOCKSTUN || state_d == BROKEN) begin
            fcnt_d = fcnt_q;
            if (bus.frame_tick && fcnt_q != '0) begin
                fcnt_d = fcnt_q - FCNT_ONE;
            end
        end else if (state_d == INHIBIT) begin
            fcnt_d = fcnt_q;
            if (state_q != INHIBIT || bus.action_start || !bus.neutral) begin
                fcnt_d = '0;
            end else if (bus.frame_tick && !bus.action_active && fcnt_q != INH_DONE) begin
                fcnt_d = fcnt_q + FCNT_ONE;
            end
        end
    end

    // Meter: block hits drain it and restart the regen delay; otherwise it creeps back up
    // one point per regen period once the delay has elapsed. BROKEN holds regen off and
    // hands back a partial refill on exit.
    always_comb begin
        meter_d = meter_q;
        dly_d   = dly_q;
        per_d   = per_q;
        if (state_q == BROKEN) begin
            dly_d = '0;
            per_d = '0;
            if (state_d == READY) begin
                meter_d = METER_REFILL;
            end
        end else if (blockhit_ok) begin
            meter_d = meter_sub;
            dly_d   = '0;
            per_d   = '0;
        end else if (bus.frame_tick) begin
            if (dly_q != DLY_MAX) begin
                dly_d = dly_q + 1'b1;
            end else if (per_q == PER_LAST) begin
                per_d = '0;
                if (meter_q < METER_FULL) begin
                    meter_d = meter_q + 1'b1;
                end
            end else begin
                per_d = per_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    // The stance is locked for the whole of blockstun.
    always_comb begin
        is_blocking_d  = (state_d == GUARDING) || (state_d == BLOCKSTUN);
        blockstun_d    = (state_d == BLOCKSTUN);
        guard_broken_d = (state_d == BROKEN);
        break_pulse_d  = break_now;
        block_low_d    = 1'b0;
        if (is_blocking_d) begin
            block_low_d = (state_q == BLOCKSTUN && state_d == BLOCKSTUN) ? block_low_q
                                                                           : stance_low;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q         <= '0;
            meter_q        <= METER_FULL;
            dly_q          <= '0;
            per_q          <= '0;
            is_blocking_q  <= 1'b0;
            block_low_q    <= 1'b0;
            blockstun_q    <= 1'b0;
            guard_broken_q <= 1'b0;
            break_pulse_q  <= 1'b0;
        end else begin
            fcnt_q         <= fcnt_d;
            meter_q        <= meter_d;
            dly_q          <= dly_d;
            per_q          <= per_d;
            is_blocking_q  <= is_blocking_d;
            block_low_q    <= block_low_d;
            blockstun_q    <= blockstun_d;
            guard_broken_q <= guard_broken_d;
            break_pulse_q  <= break_pulse_d;
        end
    end

    assign bus.is_blocking       = is_blocking_q;
    assign bus.block_low         = block_low_q;
    assign bus.blockstun         = blockstun_q;
    assign bus.guard_broken      = guard_broken_q;
    assign bus.guard_break_pulse = break_pulse_q;
    assign bus.guard_meter       = meter_q;

endmodule

// File: tb/tb_core_player_guard.sv
// tb_core_player_guard
// Self-checking bench for core_player_guard: a table of single-cycle stance/threat vectors
// followed by hand-written multi-frame sequences (threat memory, action inhibit, blockstun
// reload, regen, guard break and reset during blockstun).
module tb_core_player_guard;

    typedef struct {
        logic [3:0] act;
        logic [3:0] grab;
        logic [3:0] low;
        logic [3:0] ovh;
        logic [3:0] rng;
        logic       front;
        logic       crouch;
        logic       hit;
        logic       exp_blk;
        logic       exp_low;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[15];

    core_player_guard_if #(.NUM_HB(4), .METER_W(8)) bus();

    core_player_guard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case a sequence ever stalls.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // One game frame: a single-cycle strobe followed by a quiet cycle.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            stepClk();
            bus.frame_tick = 1'b0;
            stepClk();
        end
    endtask

    task automatic clearInputs();
        bus.frame_tick         = 1'b0;
        bus.op_hitbox_active   = '0;
        bus.op_is_grab         = '0;
        bus.op_is_low          = '0;
        bus.op_is_overhead     = '0;
        bus.within_guard_range = '0;
        bus.in_front           = 1'b1;
        bus.crouch_held        = 1'b0;
        bus.action_active      = 1'b0;
        bus.action_start       = 1'b0;
        bus.neutral            = 1'b1;
        bus.hitstun            = 1'b0;
        bus.blockhit_pulse     = 1'b0;
        bus.blockhit_cost      = '0;
    endtask

    task automatic setMidThreat(input logic [3:0] ch);
        bus.op_hitbox_active   = ch;
        bus.within_guard_range = ch;
        bus.op_is_grab         = '0;
        bus.op_is_low          = '0;
        bus.op_is_overhead     = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.op_hitbox_active   = v.act;
        bus.op_is_grab         = v.grab;
        bus.op_is_low          = v.low;
        bus.op_is_overhead     = v.ovh;
        bus.within_guard_range = v.rng;
        bus.in_front           = v.front;
        bus.crouch_held        = v.crouch;
        bus.hitstun            = v.hit;
        bus.frame_tick         = 1'b0;
    endtask

    task automatic blockhit(input logic [7:0] cost);
        bus.blockhit_cost  = cost;
        bus.blockhit_pulse = 1'b1;
        stepClk();
        bus.blockhit_pulse = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        #3;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        stepClk();
    endtask

    initial begin
        // act grab low ovh rng front crouch hit | blk low
        vecs[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'h3, 4'h0, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset values while reset is held.
        clearInputs();
        rst_n = 1'b0;
        #12;
        checkOutput("rst_is_blocking", int'(bus.is_blocking), 0);
        checkOutput("rst_block_low", int'(bus.block_low), 0);
        checkOutput("rst_blockstun", int'(bus.blockstun), 0);
        checkOutput("rst_guard_broken", int'(bus.guard_broken), 0);
        checkOutput("rst_break_pulse", int'(bus.guard_break_pulse), 0);
        checkOutput("rst_meter", int'(bus.guard_meter), 100);
        rst_n = 1'b1;
        stepClk();

        // Table: one clock per vector, no frame ticks, so only current threats count.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            stepClk();
            checkOutput($sformatf("vec%0d_is_blocking", i), int'(bus.is_blocking), int'(vecs[i].exp_blk));
            checkOutput($sformatf("vec%0d_block_low", i), int'(bus.block_low), int'(vecs[i].exp_low));
        end

        // Threat memory: ch2 for one clock on a frame tick, then held for 3 more frames.
        clearInputs();
        stepClk();
        setMidThreat(4'h4);
        bus.frame_tick = 1'b1;
        stepClk();
        bus.frame_tick = 1'b0;
        setMidThreat(4'h0);
        checkOutput("win_first_clk", int'(bus.is_blocking), 1);
        tick(1);
        checkOutput("win_after_tick1", int'(bus.is_blocking), 1);
        tick(1);
        checkOutput("win_after_tick2", int'(bus.is_blocking), 1);
        tick(1);
        checkOutput("win_after_tick3", int'(bus.is_blocking), 0);

        // Action inhibit: guard drops on action_start and re-arms after 2 neutral frames.
        setMidThreat(4'h2);
        stepClk();
        checkOutput("inh_guarding", int'(bus.is_blocking), 1);
        bus.action_start = 1'b1;
        stepClk();
        bus.action_start = 1'b0;
        checkOutput("inh_action_drop", int'(bus.is_blocking), 0);
        tick(1);
        stepClk();
        stepClk();
        checkOutput("inh_one_tick", int'(bus.is_blocking), 0);
        tick(1);
        checkOutput("inh_two_ticks_ready", int'(bus.is_blocking), 0);
        stepClk();
        checkOutput("inh_rearmed", int'(bus.is_blocking), 1);
        setMidThreat(4'h0);
        stepClk();

        // Blockstun reload, frozen stance and regen timing.
        doReset();
        setMidThreat(4'h2);
        stepClk();
        blockhit(8'd1);
        checkOutput("stun_entry", int'(bus.blockstun), 1);
        checkOutput("stun_meter99", int'(bus.guard_meter), 99);
        tick(3);
        blockhit(8'd1);
        tick(3);
        blockhit(8'd1);
        checkOutput("stun_meter97", int'(bus.guard_meter), 97);
        bus.crouch_held = 1'b1;
        tick(7);
        checkOutput("stun_held_7", int'(bus.blockstun), 1);
        checkOutput("stun_low_frozen", int'(bus.block_low), 0);
        tick(1);
        checkOutput("stun_done_8", int'(bus.blockstun), 0);
        checkOutput("stun_back_guarding", int'(bus.is_blocking), 1);
        checkOutput("stun_low_unfrozen", int'(bus.block_low), 1);
        bus.crouch_held = 1'b0;
        setMidThreat(4'h0);
        tick(25);
        checkOutput("regen_wait_33", int'(bus.guard_meter), 97);
        tick(1);
        checkOutput("regen_first_34", int'(bus.guard_meter), 98);
        tick(3);
        checkOutput("regen_hold_37", int'(bus.guard_meter), 98);
        tick(1);
        checkOutput("regen_second_38", int'(bus.guard_meter), 99);

        // Guard break: 100 -> 10 -> saturating to 0, broken for 40 frames, refill to 50.
        doReset();
        setMidThreat(4'h2);
        stepClk();
        blockhit(8'd90);
        checkOutput("brk_meter10", int'(bus.guard_meter), 10);
        blockhit(8'd25);
        checkOutput("brk_meter0", int'(bus.guard_meter), 0);
        checkOutput("brk_pulse", int'(bus.guard_break_pulse), 1);
        checkOutput("brk_broken", int'(bus.guard_broken), 1);
        checkOutput("brk_not_blocking", int'(bus.is_blocking), 0);
        stepClk();
        checkOutput("brk_pulse_single", int'(bus.guard_break_pulse), 0);
        tick(39);
        checkOutput("brk_still_39", int'(bus.guard_broken), 1);
        checkOutput("brk_no_regen", int'(bus.guard_meter), 0);
        tick(1);
        checkOutput("brk_over_40", int'(bus.guard_broken), 0);
        checkOutput("brk_refill", int'(bus.guard_meter), 50);
        checkOutput("brk_guard_again", int'(bus.is_blocking), 1);

        // Asynchronous reset in the middle of blockstun.
        blockhit(8'd5);
        checkOutput("rstmid_in_stun", int'(bus.blockstun), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_is_blocking", int'(bus.is_blocking), 0);
        checkOutput("rstmid_blockstun", int'(bus.blockstun), 0);
        checkOutput("rstmid_block_low", int'(bus.block_low), 0);
        checkOutput("rstmid_meter", int'(bus.guard_meter), 100);
        clearInputs();
        #10;
        rst_n = 1'b1;
        stepClk();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
